// File: rtl/pong_pkg.sv
// Shared Pong encodings: game-state codes, ball FSM states, winner codes and
// default screen geometry used by the VGA timing, paddle and ball blocks.
package pong_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;
  localparam int SPEED_W      = 4;

  localparam logic [1:0] GS_PLAY = 2'b01;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/ball_engine_if.sv
// Ball engine signal bundle: motion enable, pixel and paddle coordinates in,
// ball position, scores and event pulses out.
interface ball_engine_if;
  import pong_pkg::*;

  logic               tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] x_paddle1;
  logic [COORD_W-1:0] y_paddle1;
  logic [COORD_W-1:0] x_paddle2;
  logic [COORD_W-1:0] y_paddle2;
  logic [1:0]         game_state;
  logic               ball_on;
  logic [COORD_W-1:0] x_ball;
  logic [COORD_W-1:0] y_ball;
  logic [3:0]         p1_score;
  logic [3:0]         p2_score;
  logic [1:0]         winner;
  logic               hit;
  logic               point;

  modport master (
    output tick, x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2, game_state,
    input  ball_on, x_ball, y_ball, p1_score, p2_score, winner, hit, point
  );

  modport slave (
    input  tick, x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2, game_state,
    output ball_on, x_ball, y_ball, p1_score, p2_score, winner, hit, point
  );

endinterface

// File: rtl/ball_collide.sv
// Combinational single-step ball motion: wall clamping, paddle reflection and
// miss detection, all in 12-bit signed arithmetic so off-screen values never wrap.
module ball_collide
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 80,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 4,
  parameter int HITS_PER_UP = 4,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 500
) (
  input  logic [COORD_W-1:0] x_ball,
  input  logic [COORD_W-1:0] y_ball,
  input  logic               dx_pos,
  input  logic               dy_pos,
  input  logic [SPEED_W-1:0] speed,
  input  logic [COORD_W-1:0] x_paddle1,
  input  logic [COORD_W-1:0] y_paddle1,
  input  logic [COORD_W-1:0] x_paddle2,
  input  logic [COORD_W-1:0] y_paddle2,
  output logic [COORD_W-1:0] x_next,
  output logic [COORD_W-1:0] y_next,
  output logic               dx_pos_next,
  output logic               dy_pos_next,
  output logic               hit,
  output logic               miss_left,
  output logic               miss_right
);

  if ((BALL_SIZE % 2) != 0 || (PADDLE_W % 2) != 0 || (PADDLE_H % 2) != 0 ||
      WIN_SCORE > 15 || SPEED_INIT < 1 || SPEED_MAX < SPEED_INIT || SPEED_MAX > 15 ||
      HITS_PER_UP < 1 || SERVE_TICKS < 1 || H_ACTIVE > 1023 || V_ACTIVE > 1023) begin : g_param_check
    $error("ball_collide: illegal parameter set");
  end

  localparam logic signed [11:0] HB    = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] HPW   = 12'(PADDLE_W / 2);
  localparam logic signed [11:0] Y_HI  = 12'(V_ACTIVE - 1 - BALL_SIZE / 2);
  localparam logic signed [11:0] X_HI  = 12'(H_ACTIVE - BALL_SIZE / 2);
  localparam logic signed [11:0] REACH = 12'((PADDLE_H + BALL_SIZE) / 2);

  logic signed [11:0] xb, yb, sp, nx, ny;
  logic signed [11:0] xp1, yp1, xp2, yp2, ofs1, ofs2;
  logic               near1, near2, hit_r, hit_l;

  assign xb   = $signed({2'b00, x_ball});
  assign yb   = $signed({2'b00, y_ball});
  assign sp   = $signed({{(12 - SPEED_W){1'b0}}, speed});
  assign xp1  = $signed({2'b00, x_paddle1});
  assign yp1  = $signed({2'b00, y_paddle1});
  assign xp2  = $signed({2'b00, x_paddle2});
  assign yp2  = $signed({2'b00, y_paddle2});
  assign nx   = dx_pos ? (xb + sp) : (xb - sp);
  assign ny   = dy_pos ? (yb + sp) : (yb - sp);

  // Vertical overlap uses the current ball row, not the candidate one
  assign ofs1  = yb - yp1;
  assign ofs2  = yb - yp2;
  assign near1 = (ofs1 < REACH) && (ofs1 > -REACH);
  assign near2 = (ofs2 < REACH) && (ofs2 > -REACH);
  assign hit_r = dx_pos  && (nx + HB >= xp2 - HPW) && (nx <= xp2) && near2;
  assign hit_l = !dx_pos && (nx - HB <= xp1 + HPW) && (nx >= xp1) && near1;

  always_comb begin
    y_next      = 10'(ny);
    dy_pos_next = dy_pos;
    if (ny <= HB) begin
      y_next      = 10'(HB);
      dy_pos_next = 1'b1;
    end else if (ny >= Y_HI) begin
      y_next      = 10'(Y_HI);
      dy_pos_next = 1'b0;
    end

    x_next      = 10'(nx);
    dx_pos_next = dx_pos;
    if (hit_r) begin
      x_next      = 10'(xp2 - HPW - HB);
      dx_pos_next = 1'b0;
    end else if (hit_l) begin
      x_next      = 10'(xp1 + HPW + HB);
      dx_pos_next = 1'b1;
    end

    hit        = hit_r || hit_l;
    miss_right = !hit && (nx >= X_HI);
    miss_left  = !hit && (nx <= HB);
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve/play/over FSM, scoring, speed ramp and winner latch
// around the combinational ball_collide step; ball_on paints the ball square.
module ball_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 80,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 4,
  parameter int HITS_PER_UP = 4,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 500
) (
  input logic          clk,
  input logic          reset,
  ball_engine_if.slave bus
);

  localparam int                 CNT_W = $clog2(SERVE_TICKS + 1);
  localparam int                 HC_W  = $clog2(HITS_PER_UP + 1);
  localparam logic [9:0]         X_MID = 10'(H_ACTIVE / 2);
  localparam logic [9:0]         Y_MID = 10'(V_ACTIVE / 2);
  localparam logic signed [11:0] HB    = 12'(BALL_SIZE / 2);

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         win_q, win_d;
  logic               hit_q, hit_d, point_q, point_d;

  logic [9:0] x_col, y_col;
  logic       dx_col, dy_col, hit_col, miss_l, miss_r, adv;

  assign adv = bus.tick && (bus.game_state == GS_PLAY);

  ball_collide #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BALL_SIZE(BALL_SIZE),
    .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .SPEED_INIT(SPEED_INIT),
    .SPEED_MAX(SPEED_MAX), .HITS_PER_UP(HITS_PER_UP), .WIN_SCORE(WIN_SCORE),
    .SERVE_TICKS(SERVE_TICKS)
  ) u_collide (
    .x_ball(x_q), .y_ball(y_q), .dx_pos(dx_pos_q), .dy_pos(dy_pos_q), .speed(speed_q),
    .x_paddle1(bus.x_paddle1), .y_paddle1(bus.y_paddle1),
    .x_paddle2(bus.x_paddle2), .y_paddle2(bus.y_paddle2),
    .x_next(x_col), .y_next(y_col), .dx_pos_next(dx_col), .dy_pos_next(dy_col),
    .hit(hit_col), .miss_left(miss_l), .miss_right(miss_r)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    speed_d  = speed_q;
    hc_d     = hc_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    win_d    = win_q;
    hit_d    = 1'b0;
    point_d  = 1'b0;
    if (adv) begin
      unique case (state_q)
        SERVE: begin
          if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PLAY: begin
          if (miss_l || miss_r) begin
            // Ball restarts from centre heading at whoever conceded
            point_d  = 1'b1;
            speed_d  = SPEED_W'(SPEED_INIT);
            hc_d     = '0;
            x_d      = X_MID;
            y_d      = Y_MID;
            dy_pos_d = ~dy_pos_q;
            state_d  = SERVE;
            if (miss_r) begin
              p1_d     = p1_q + 4'd1;
              dx_pos_d = 1'b1;
              if (p1_d == 4'(WIN_SCORE)) begin
                win_d   = WIN_P1;
                state_d = OVER;
              end
            end else begin
              p2_d     = p2_q + 4'd1;
              dx_pos_d = 1'b0;
              if (p2_d == 4'(WIN_SCORE)) begin
                win_d   = WIN_P2;
                state_d = OVER;
              end
            end
          end else begin
            x_d      = x_col;
            y_d      = y_col;
            dx_pos_d = dx_col;
            dy_pos_d = dy_col;
            if (hit_col) begin
              hit_d = 1'b1;
              if (hc_q + HC_W'(1) == HC_W'(HITS_PER_UP)) begin
                hc_d = '0;
                if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
              end else begin
                hc_d = hc_q + HC_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SERVE;
      x_q      <= X_MID;
      y_q      <= Y_MID;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b0;
      speed_q  <= SPEED_W'(SPEED_INIT);
      hc_q     <= '0;
      cnt_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      win_q    <= WIN_NONE;
      hit_q    <= 1'b0;
      point_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
      speed_q  <= speed_d;
      hc_q     <= hc_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      win_q    <= win_d;
      hit_q    <= hit_d;
      point_q  <= point_d;
    end
  end

  // Signed pixel offsets so a ball hugging the screen edge does not wrap
  logic signed [11:0] bx_diff, by_diff;
  assign bx_diff = $signed({2'b00, bus.x}) - $signed({2'b00, x_q});
  assign by_diff = $signed({2'b00, bus.y}) - $signed({2'b00, y_q});

  assign bus.ball_on  = (bx_diff >= -HB) && (bx_diff <= HB) &&
                        (by_diff >= -HB) && (by_diff <= HB);
  assign bus.x_ball   = x_q;
  assign bus.y_ball   = y_q;
  assign bus.p1_score = p1_q;
  assign bus.p2_score = p2_q;
  assign bus.winner   = win_q;
  assign bus.hit      = hit_q;
  assign bus.point    = point_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: integer game model driven by the same
// stimulus, compared against every DUT output once per clock.
module tb_ball_engine;
  import pong_pkg::*;

  localparam int H = 640, V = 480, BS = 16, PAD_W = 16, PAD_H = 80;
  localparam int SP0 = 1, SPM = 4, HPU = 4, WIN = 11, ST = 500;
  localparam int HB = BS / 2;
  localparam int PH_SERVE = 0, PH_RALLY = 1, PH_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_engine_if bus();

  ball_engine #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BALL_SIZE(BS), .PADDLE_W(PAD_W), .PADDLE_H(PAD_H),
    .SPEED_INIT(SP0), .SPEED_MAX(SPM), .HITS_PER_UP(HPU), .WIN_SCORE(WIN),
    .SERVE_TICKS(ST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_x, m_y, m_dx, m_dy, m_spd, m_hc, m_cnt, m_p1, m_p2, m_win, m_phase;
  int m_hit, m_point;
  int rally_hits, xp1_sel, xp2_sel;
  bit miss1, miss2;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic new_rally();
    miss1      = ($urandom % 2) == 0;
    miss2      = ($urandom % 6) == 0;
    rally_hits = 0;
    xp1_sel    = ($urandom % 2) ? 40 : 25 + int'($urandom % 30);
    xp2_sel    = ($urandom % 2) ? 600 : 585 + int'($urandom % 30);
  endtask

  task automatic model_reset();
    m_x = H / 2; m_y = V / 2; m_dx = 1; m_dy = -1;
    m_spd = SP0; m_hc = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    m_phase = PH_SERVE; m_hit = 0; m_point = 0;
    new_rally();
  endtask

  task automatic model_tick(input int xp1, input int yp1, input int xp2, input int yp2);
    int nx, ny, ynew, dynew;
    bit hr, hl;
    case (m_phase)
      PH_SERVE: begin
        if (m_cnt == ST - 1) begin
          m_cnt   = 0;
          m_phase = PH_RALLY;
        end else begin
          m_cnt++;
        end
      end
      PH_RALLY: begin
        nx = m_x + m_dx * m_spd;
        ny = m_y + m_dy * m_spd;
        ynew = ny; dynew = m_dy;
        if (ny <= HB) begin
          ynew = HB; dynew = 1;
        end else if (ny >= V - 1 - HB) begin
          ynew = V - 1 - HB; dynew = -1;
        end
        hr = (m_dx == 1) && (nx + HB >= xp2 - PAD_W / 2) && (nx <= xp2) &&
             (iabs(m_y - yp2) < (PAD_H + BS) / 2);
        hl = (m_dx == -1) && (nx - HB <= xp1 + PAD_W / 2) && (nx >= xp1) &&
             (iabs(m_y - yp1) < (PAD_H + BS) / 2);
        if (hr || hl) begin
          m_x  = hr ? xp2 - PAD_W / 2 - HB : xp1 + PAD_W / 2 + HB;
          m_dx = -m_dx;
          m_y  = ynew; m_dy = dynew;
          m_hit = 1;
          rally_hits++;
          m_hc++;
          if (m_hc == HPU) begin
            m_hc = 0;
            if (m_spd < SPM) m_spd++;
          end
        end else if (nx >= H - HB || nx <= HB) begin
          m_point = 1;
          if (nx >= H - HB) begin
            m_p1++; m_dx = 1;
            if (m_p1 == WIN) m_win = 1;
          end else begin
            m_p2++; m_dx = -1;
            if (m_p2 == WIN) m_win = 2;
          end
          m_spd = SP0; m_hc = 0; m_x = H / 2; m_y = V / 2; m_dy = -m_dy;
          m_phase = (m_win != 0) ? PH_DONE : PH_SERVE;
        end else begin
          m_x = nx; m_y = ynew; m_dy = dynew;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int paddle_y(input bit miss);
    int v;
    if (miss) return (m_y < V / 2) ? m_y + 200 : m_y - 200;
    v = m_y + int'($urandom % 81) - 40;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int near_coord(input int c);
    int v;
    if (($urandom % 4) == 0) return int'($urandom % 1024);
    v = c + int'($urandom % 25) - 12;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic step_cycle(input bit rst, input bit tk, input logic [1:0] gs);
    int yp1, yp2, xq, yq;
    @(negedge clk);
    reset = rst;
    bus.tick = tk;
    bus.game_state = gs;
    yp1 = paddle_y(miss1 || rally_hits >= 4);
    yp2 = paddle_y(miss2 || rally_hits >= 4);
    if (tk) begin
      bus.x_paddle1 = 10'(xp1_sel); bus.y_paddle1 = 10'(yp1);
      bus.x_paddle2 = 10'(xp2_sel); bus.y_paddle2 = 10'(yp2);
    end else begin
      bus.x_paddle1 = 10'($urandom); bus.y_paddle1 = 10'($urandom);
      bus.x_paddle2 = 10'($urandom); bus.y_paddle2 = 10'($urandom);
    end
    xq = near_coord(m_x);
    yq = near_coord(m_y);
    bus.x = 10'(xq);
    bus.y = 10'(yq);
    @(posedge clk);
    m_hit = 0; m_point = 0;
    if (rst) model_reset();
    else if (tk && gs == 2'b01) model_tick(xp1_sel, yp1, xp2_sel, yp2);
    if (m_point != 0) new_rally();
    #1;
    chk("x_ball", bus.x_ball, m_x);
    chk("y_ball", bus.y_ball, m_y);
    chk("hit", bus.hit, m_hit);
    chk("point", bus.point, m_point);
    chk("p1_score", bus.p1_score, m_p1);
    chk("p2_score", bus.p2_score, m_p2);
    chk("winner", bus.winner, m_win);
    chk("ball_on", bus.ball_on, (iabs(xq - m_x) <= HB && iabs(yq - m_y) <= HB) ? 1 : 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    bus.tick = 1'b0; bus.game_state = 2'b00; bus.x = '0; bus.y = '0;
    bus.x_paddle1 = '0; bus.y_paddle1 = '0; bus.x_paddle2 = '0; bus.y_paddle2 = '0;
    model_reset();

    step_cycle(1'b1, 1'b0, 2'b00);
    step_cycle(1'b1, 1'b1, 2'b01);

    repeat (ST) step_cycle(1'b0, 1'b1, 2'b01);
    chk("serve_hold_x", bus.x_ball, 320);
    chk("serve_hold_y", bus.y_ball, 240);
    step_cycle(1'b0, 1'b1, 2'b01);
    chk("first_move_x", bus.x_ball, 321);
    chk("first_move_y", bus.y_ball, 239);

    repeat (30) step_cycle(1'b0, 1'b1, 2'b01);
    repeat (20) step_cycle(1'b0, 1'b1, 2'b00);
    repeat (20) step_cycle(1'b0, 1'($urandom % 2), 2'($urandom % 4));

    guard = 0;
    while (m_win == 0 && guard < 60000) begin
      step_cycle(1'b0, ($urandom % 10) < 9,
                 (($urandom % 25) == 0) ? 2'($urandom % 4) : 2'b01);
      guard++;
    end
    chk("winner_reached", (bus.winner != 2'b00) ? 1 : 0, 1);

    repeat (40) step_cycle(1'b0, 1'b1, 2'b01);
    step_cycle(1'b1, 1'b1, 2'b01);
    chk("reset_winner", bus.winner, 0);
    chk("reset_p1", bus.p1_score, 0);
    chk("reset_p2", bus.p2_score, 0);

    repeat (700) step_cycle(1'b0, 1'b1, 2'b01);
    step_cycle(1'b1, 1'b1, 2'b01);
    repeat (600) step_cycle(1'b0, 1'b1, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball engine for the Pong datapath: advances the ball one step per `tick` enable, reflects off top and bottom walls and both paddles, and detects misses. It also keeps both scores, runs a serve delay after each point, raises ball speed after a set number of paddle hits, and latches a winner. It sits between the paddle controllers and the VGA pixel mixer. It supersedes the fixed-size, fixed-speed ball block.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible width, pixels.
- `V_ACTIVE`, 480: visible height, pixels.
- `BALL_SIZE`, 16: ball edge length. Even.
- `PADDLE_W`, 16: paddle width. Even.
- `PADDLE_H`, 80: paddle height. Even.
- `SPEED_INIT`, 1: pixels per tick per axis at serve.
- `SPEED_MAX`, 4: speed ceiling.
- `HITS_PER_UP`, 4: paddle hits per +1 speed.
- `WIN_SCORE`, 11: points to win. Must be ≤ 15.
- `SERVE_TICKS`, 500: ticks the ball is held centred before a serve.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous reset, active-high.
- `tick`, in, 1: one-cycle motion enable.
- `x`, `y`, in, 10 each: current pixel coordinate.
- `x_paddle1`, `y_paddle1`, in, 10 each: left paddle centre.
- `x_paddle2`, `y_paddle2`, in, 10 each: right paddle centre.
- `game_state`, in, 2: 2'b01 means play; any other value means pause.
- `ball_on`, out, 1: pixel (x,y) lies inside the ball.
- `x_ball`, `y_ball`, out, 10 each: ball centre.
- `p1_score`, `p2_score`, out, 4 each: scores.
- `winner`, out, 2: 00 none, 01 player 1, 10 player 2.
- `hit`, out, 1: one-cycle pulse on a paddle reflection.
- `point`, out, 1: one-cycle pulse when a point is scored.

## Operation
- FSM states: SERVE, PLAY, OVER.
- Reset sets the FSM to SERVE and places the ball at (H_ACTIVE/2, V_ACTIVE/2).
- Reset also sets: scores 0, winner 00, speed SPEED_INIT, hit count 0, serve counter 0, dx +1, dy −1, and hit/point low.
- All state advances only on cycles where `tick`=1 and `game_state`=01. Otherwise everything holds. A pause freezes the serve counter too.
- **SERVE:** ball held at centre. The counter increments each tick. When it reaches SERVE_TICKS−1, it clears and the FSM moves to PLAY.
- **PLAY, per tick:**
  - Compute a signed 12-bit candidate: nx = x_ball + dx·speed, ny = y_ball + dy·speed.
  - Wall: if ny ≤ BALL_SIZE/2, set y = BALL_SIZE/2 and dy = +1.
  - Wall: if ny ≥ V_ACTIVE−1−BALL_SIZE/2, clamp to that value and set dy = −1.
  - Right paddle hit requires all of:
    - dx = +1;
    - nx + BALL_SIZE/2 ≥ x_paddle2 − PADDLE_W/2;
    - nx ≤ x_paddle2;
    - |y_ball − y_paddle2| < (PADDLE_H + BALL_SIZE)/2.
  - On a right paddle hit: set x = x_paddle2 − PADDLE_W/2 − BALL_SIZE/2, dx = −1, and pulse `hit`.
  - The left paddle is the mirror image, using dx = −1 and x_paddle1.
  - Wall and paddle reflection in the same tick both apply.
  - On each hit, the hit count increments. When it reaches HITS_PER_UP, it clears and speed increments, saturating at SPEED_MAX.
  - Miss right (nx ≥ H_ACTIVE − BALL_SIZE/2 with no hit): p1 scores.
  - Miss left (nx ≤ BALL_SIZE/2 with no hit): p2 scores.
  - A paddle hit takes priority over a miss in the same tick.
- **On a point:**
  - Pulse `point` and increment the scorer's score.
  - Reset speed and hit count, centre the ball, and toggle dy.
  - Set dx to point toward the player who conceded.
  - If the new score equals WIN_SCORE, set `winner` and go to OVER. Otherwise go to SERVE.
- **OVER:** ball centred and everything frozen until `reset`.
- `ball_on` is combinational from the registered position, inclusive bounds: |x − x_ball| ≤ BALL_SIZE/2 and |y − y_ball| ≤ BALL_SIZE/2. Comparisons are signed, so a ball near 0 must not wrap.

## Timing
- Position, scores, winner, and FSM state update on the rising `clk` edge of a qualifying tick. New values are visible on the following cycle.
- `hit` and `point` are high for exactly that one cycle.
- `ball_on` has zero latency relative to x/y.
- A `tick` arriving while `game_state`≠01 is lost, not queued.
- `reset` overrides `tick` in the same cycle. A reset mid-rally or mid-serve returns to the reset values listed above.
- Paddle inputs are sampled on the tick cycle only. They need not be stable at other times.

## Structure
- Package `pong_pkg` holds:
  - the game_state encodings (PLAY = 2'b01);
  - the FSM enum {SERVE, PLAY, OVER};
  - the winner encodings;
  - default screen constants shared with the VGA timing block and the paddle blocks.
- Sub-module `ball_collide` is purely combinational, parametrised identically.
  - Inputs: position, direction, speed, and paddle positions.
  - Outputs: next position, next direction, hit, miss_left, miss_right.
- `ball_engine` owns the FSM, counters, scores, and registers.

## Test plan
- Reset then 500 play ticks: ball stays at (320,240) through tick 499. The first move, on tick 501, goes to (321,239).
- Ball at y=9 moving up at speed 1: next tick y=8, dy=+1. One more tick gives y=9.
- Right paddle at (600,240), ball approaching at y=240: `hit` pulses once, x = 584, dx = −1. After 4 hits, speed = 2.
- Right paddle at y=60, ball passes at y=400: `point` pulses, p1_score 0→1, ball recentred, speed resets to 1, serve delay restarts.
- p2_score at 10 and a left miss: p2_score=11, winner=10, FSM OVER. Further ticks change nothing; `reset` clears all.
- `game_state`=00 for 20 ticks mid-rally: position, counters, and scores are unchanged. Play resumes from the same point.
